// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard command sequencer and scan-code decoder.
// Drives the transceiver's command port through reset/self-test and LED
// updates (each byte ACK-checked with resend/retry), and turns the received
// byte stream into single-cycle key events with extended/release flags.
module ps2_kbd_ctrl #(
  parameter int ACK_TIMEOUT   = 1000000,
  parameter int BAT_TIMEOUT   = 50000000,
  parameter int MAX_RETRY     = 3,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       init_req,
  input  logic       led_req,
  input  logic [2:0] led_value,
  output logic [7:0] cmd_data,
  output logic       cmd_send,
  input  logic       cmd_was_sent,
  input  logic       cmd_timed_out,
  input  logic [7:0] rx_data,
  input  logic       rx_data_en,
  output logic       led_busy,
  output logic       kbd_ready,
  output logic       kbd_error,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_release
);

  // START is a one-cycle launch state so cmd_data/cmd_send are 0 in reset
  // and the 0xFF byte is loaded cleanly on the first active cycle.
  // GAP keeps cmd_send low for one extra cycle between DROP and a resend.
  typedef enum logic [2:0] {
    S_START, S_IDLE, S_SEND, S_DROP, S_GAP, S_WAIT_ACK, S_WAIT_BAT, S_ERROR
  } state_t;

  // Which byte of which sequence the shared send/ack states are serving.
  typedef enum logic [1:0] {P_INIT, P_LED_CMD, P_LED_DATA} phase_t;

  localparam logic [31:0] ACK_LAST  = 32'(ACK_TIMEOUT - 1);
  localparam logic [31:0] BAT_LAST  = 32'(BAT_TIMEOUT - 1);
  localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);

  state_t      state, state_n;
  phase_t      phase, phase_n;
  logic [7:0]  cmd_n;
  logic [7:0]  retry, retry_n;
  logic [31:0] timer, timer_n;
  logic        redo, redo_n;
  logic        ready_n, error_n;
  logic        led_start, consumed, fail, start_init;
  logic        in_xfer, drop_ctx, is_filler;
  logic        pending;
  logic [2:0]  led_val, seq_val;
  logic        ext, brk;

  assign in_xfer   = state inside {S_SEND, S_DROP, S_GAP, S_WAIT_ACK};
  assign cmd_send  = (state == S_SEND);
  assign led_busy  = pending | (in_xfer && phase != P_INIT);
  assign is_filler = rx_data inside {8'hFA, 8'hFE, 8'hAA, 8'hEE, 8'h00, 8'hFF};
  assign drop_ctx  = (state == S_IDLE) || (in_xfer && phase != P_INIT);

  // Sequencer state, command byte, retry/timer and status flags.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state     <= INIT_ON_RESET ? S_START : S_IDLE;
      phase     <= P_INIT;
      cmd_data  <= 8'h00;
      retry     <= '0;
      timer     <= '0;
      redo      <= 1'b0;
      kbd_ready <= ~INIT_ON_RESET;
      kbd_error <= 1'b0;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      cmd_data  <= cmd_n;
      retry     <= retry_n;
      timer     <= timer_n;
      redo      <= redo_n;
      kbd_ready <= ready_n;
      kbd_error <= error_n;
    end
  end

  // Next-state: byte send/drop/ack handshake, retry accounting, init and LED flow.
  always_comb begin
    state_n    = state;
    phase_n    = phase;
    cmd_n      = cmd_data;
    retry_n    = retry;
    timer_n    = '0;
    redo_n     = redo;
    ready_n    = kbd_ready;
    error_n    = kbd_error;
    led_start  = 1'b0;
    consumed   = 1'b0;
    fail       = 1'b0;
    start_init = 1'b0;
    case (state)
      S_START: start_init = 1'b1;
      S_IDLE: begin
        if (init_req) start_init = 1'b1;
        else if (pending && kbd_ready) begin
          state_n   = S_SEND;
          phase_n   = P_LED_CMD;
          cmd_n     = 8'hED;
          retry_n   = '0;
          led_start = 1'b1;
        end
      end
      S_SEND: begin
        if (cmd_was_sent) begin
          state_n = S_DROP;
          redo_n  = 1'b0;
        end else if (cmd_timed_out) begin
          fail = 1'b1;
        end
      end
      S_DROP: state_n = redo ? S_GAP : S_WAIT_ACK;
      S_GAP:  state_n = S_SEND;
      S_WAIT_ACK: begin
        timer_n = timer + 32'd1;
        if (rx_data_en && rx_data == 8'hFA) begin
          consumed = 1'b1;
          case (phase)
            P_INIT: begin
              state_n = S_WAIT_BAT;
              timer_n = '0;
            end
            P_LED_CMD: begin
              state_n = S_SEND;
              phase_n = P_LED_DATA;
              cmd_n   = {5'b0, seq_val};
              retry_n = '0;
            end
            default: state_n = S_IDLE;
          endcase
        end else if (rx_data_en && rx_data == 8'hFE) begin
          consumed = 1'b1;
          fail     = 1'b1;
        end else if (timer == ACK_LAST) begin
          fail = 1'b1;
        end
      end
      S_WAIT_BAT: begin
        timer_n = timer + 32'd1;
        if (rx_data_en && rx_data == 8'hAA) begin
          consumed = 1'b1;
          state_n  = S_IDLE;
          ready_n  = 1'b1;
        end else if (rx_data_en && (rx_data == 8'hFC || rx_data == 8'hFD)) begin
          consumed = 1'b1;
          state_n  = S_ERROR;
          error_n  = 1'b1;
          ready_n  = 1'b0;
        end else if (timer == BAT_LAST) begin
          state_n = S_ERROR;
          error_n = 1'b1;
          ready_n = 1'b0;
        end
      end
      S_ERROR: if (init_req) start_init = 1'b1;
      default: state_n = S_IDLE;
    endcase
    // A failed attempt resends the same byte until the retry budget is spent.
    // A send timeout must first drop cmd_send; a NAK/ack timeout resends directly.
    if (fail) begin
      if (retry == RETRY_MAX) begin
        state_n = S_ERROR;
        error_n = 1'b1;
        ready_n = 1'b0;
      end else begin
        retry_n = retry + 8'd1;
        redo_n  = 1'b1;
        state_n = (state == S_SEND) ? S_DROP : S_SEND;
      end
    end
    if (start_init) begin
      state_n = S_SEND;
      phase_n = P_INIT;
      cmd_n   = 8'hFF;
      retry_n = '0;
      error_n = 1'b0;
      ready_n = 1'b0;
    end
  end

  // LED request latch: last value wins; the sequence works from a snapshot
  // taken when it starts, so a request during a sequence queues another one.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      pending <= 1'b0;
      led_val <= '0;
      seq_val <= '0;
    end else begin
      if (led_req) begin
        pending <= 1'b1;
        led_val <= led_value;
      end else if (led_start) begin
        pending <= 1'b0;
      end
      if (led_start) seq_val <= led_val;
    end
  end

  // Scan-code decoder: prefixes set flags, codes emit a one-cycle event.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      ext          <= 1'b0;
      brk          <= 1'b0;
      key_valid    <= 1'b0;
      key_code     <= 8'h00;
      key_extended <= 1'b0;
      key_release  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (rx_data_en && !consumed) begin
        if (rx_data == 8'hE0) ext <= 1'b1;
        else if (rx_data == 8'hF0) brk <= 1'b1;
        else if (!(drop_ctx && is_filler)) begin
          key_valid    <= 1'b1;
          key_code     <= rx_data;
          key_extended <= ext;
          key_release  <= brk;
          ext          <= 1'b0;
          brk          <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Bench for ps2_kbd_ctrl: emulates the transceiver and keyboard, predicts
// command bytes and key events into scoreboards checked by monitors.
module tb_ps2_kbd_ctrl;
  localparam int ACK_T = 100;
  localparam int BAT_T = 500;
  localparam int MAXR  = 3;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b0;
  logic       init_req = 1'b0;
  logic       led_req = 1'b0;
  logic [2:0] led_value = 3'd0;
  logic [7:0] cmd_data;
  logic       cmd_send;
  logic       cmd_was_sent = 1'b0;
  logic       cmd_timed_out = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_data_en = 1'b0;
  logic       led_busy, kbd_ready, kbd_error, key_valid;
  logic [7:0] key_code;
  logic       key_extended, key_release;

  ps2_kbd_ctrl #(.ACK_TIMEOUT(ACK_T), .BAT_TIMEOUT(BAT_T), .MAX_RETRY(MAXR),
                 .INIT_ON_RESET(1'b1)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .init_req(init_req), .led_req(led_req),
    .led_value(led_value), .cmd_data(cmd_data), .cmd_send(cmd_send),
    .cmd_was_sent(cmd_was_sent), .cmd_timed_out(cmd_timed_out),
    .rx_data(rx_data), .rx_data_en(rx_data_en), .led_busy(led_busy),
    .kbd_ready(kbd_ready), .kbd_error(kbd_error), .key_valid(key_valid),
    .key_code(key_code), .key_extended(key_extended), .key_release(key_release)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       rel;
    int         at;
  } key_t;

  key_t       exp_key[$];
  logic [7:0] exp_cmd[$];
  int checks = 0;
  int errors = 0;

  // Transceiver emulation controls.
  bit tx_hold = 1'b0;
  int tx_fail_cnt = 0;

  // Keyboard-side decode model state.
  bit m_ext = 1'b0;
  bit m_brk = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_range(input string nm, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, got, lo, hi);
    end
  endtask

  // Transceiver: completes each send after a short random delay, or reports
  // a send timeout while tx_fail_cnt is non-zero; stays silent under tx_hold.
  initial begin
    forever begin
      @(negedge CLOCK_50);
      if (cmd_send && !tx_hold) begin
        repeat ($urandom_range(0, 2)) @(negedge CLOCK_50);
        @(posedge CLOCK_50); #1;
        if (tx_fail_cnt > 0) begin
          cmd_timed_out = 1'b1;
          tx_fail_cnt--;
        end else begin
          cmd_was_sent = 1'b1;
        end
        @(posedge CLOCK_50); #1;
        cmd_was_sent  = 1'b0;
        cmd_timed_out = 1'b0;
      end
    end
  end

  // Command monitor: every rising cmd_send must match the next predicted byte.
  initial begin
    logic       prev;
    logic [7:0] e;
    prev = 1'b0;
    forever begin
      @(negedge CLOCK_50);
      if (cmd_send && !prev) begin
        if (exp_cmd.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cmd_unexpected: got %0h expected none", cmd_data);
        end else begin
          e = exp_cmd.pop_front();
          chk("cmd_byte", 32'(cmd_data), 32'(e));
        end
      end
      prev = cmd_send;
    end
  end

  // Key monitor: every key_valid must match the next predicted event and cycle.
  initial begin
    key_t e;
    forever begin
      @(negedge CLOCK_50);
      if (key_valid) begin
        if (exp_key.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL key_unexpected: got %0h expected none", key_code);
        end else begin
          e = exp_key.pop_front();
          chk("key_fields", 32'({key_code, key_extended, key_release}),
              32'({e.code, e.ext, e.rel}));
          chk("key_latency", 32'(cyc), 32'(e.at));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic pulse_init();
    @(posedge CLOCK_50); #1; init_req = 1'b1;
    @(posedge CLOCK_50); #1; init_req = 1'b0;
  endtask

  task automatic pulse_led(input logic [2:0] v);
    @(posedge CLOCK_50); #1; led_req = 1'b1; led_value = v;
    @(posedge CLOCK_50); #1; led_req = 1'b0;
  endtask

  // Keyboard sends one byte; when modelled, predict the key event from the
  // scan-code rules (prefix flags, filler bytes ignored, code emits event).
  task automatic kbd_rx(input logic [7:0] b, input bit model);
    key_t k;
    @(posedge CLOCK_50); #1; rx_data = b; rx_data_en = 1'b1;
    @(posedge CLOCK_50); #1; rx_data_en = 1'b0;
    if (model) begin
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else if (!(b inside {8'hFA, 8'hFE, 8'hAA, 8'hEE, 8'h00, 8'hFF})) begin
        k.code = b; k.ext = m_ext; k.rel = m_brk; k.at = cyc;
        exp_key.push_back(k);
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
    end
  endtask

  // Wait for one complete cmd_send high/low pulse, bounded.
  task automatic wait_sent(input string nm);
    int n;
    n = 0;
    while (!cmd_send && n < 300) begin @(negedge CLOCK_50); n++; end
    while (cmd_send && n < 300) begin @(negedge CLOCK_50); n++; end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL %s: got no send expected send within 300 cycles", nm);
    end
  endtask

  // Acknowledge the pending 0xFF and pass self-test.
  task automatic finish_init(input string nm);
    wait_sent(nm);
    kbd_rx(8'hFA, 1'b0);
    repeat (3) @(posedge CLOCK_50);
    kbd_rx(8'hAA, 1'b0);
    @(negedge CLOCK_50);
    chk({nm, "_ready"}, 32'(kbd_ready), 32'd1);
    chk({nm, "_error"}, 32'(kbd_error), 32'd0);
  endtask

  initial begin
    logic [2:0] v, v2;
    logic [7:0] b;
    int n, r;
    bit busy_drop;

    // Reset state.
    #12;
    chk("rst_cmd_send", 32'(cmd_send), 32'd0);
    chk("rst_cmd_data", 32'(cmd_data), 32'h00);
    chk("rst_ready", 32'(kbd_ready), 32'd0);
    chk("rst_error", 32'(kbd_error), 32'd0);
    chk("rst_busy", 32'(led_busy), 32'd0);
    chk("rst_key_valid", 32'(key_valid), 32'd0);
    exp_cmd.push_back(8'hFF);
    @(posedge CLOCK_50); #1; reset = 1'b1;
    finish_init("init");

    // LED update with one NAK.
    v = 3'($urandom_range(0, 7));
    exp_cmd.push_back(8'hED);
    pulse_led(v);
    chk("led_busy_req", 32'(led_busy), 32'd1);
    wait_sent("led_ed");
    exp_cmd.push_back(8'hED);
    kbd_rx(8'hFE, 1'b0);
    wait_sent("led_ed_resend");
    exp_cmd.push_back({5'b0, v});
    kbd_rx(8'hFA, 1'b0);
    wait_sent("led_data");
    chk("led_busy_mid", 32'(led_busy), 32'd1);
    kbd_rx(8'hFA, 1'b0);
    @(negedge CLOCK_50);
    chk("led_busy_done", 32'(led_busy), 32'd0);

    // LED update with a transceiver send timeout on the first byte.
    v = 3'b101;
    tx_fail_cnt = 1;
    exp_cmd.push_back(8'hED);
    exp_cmd.push_back(8'hED);
    pulse_led(v);
    wait_sent("txto_first");
    wait_sent("txto_resend");
    exp_cmd.push_back(8'h05);
    kbd_rx(8'hFA, 1'b0);
    wait_sent("txto_data");
    kbd_rx(8'hFA, 1'b0);
    @(negedge CLOCK_50);
    chk("txto_busy_done", 32'(led_busy), 32'd0);
    chk("txto_error", 32'(kbd_error), 32'd0);

    // Decoder: directed then randomized stream in IDLE.
    kbd_rx(8'hE0, 1'b1);
    kbd_rx(8'hF0, 1'b1);
    kbd_rx(8'h75, 1'b1);
    kbd_rx(8'h1C, 1'b1);
    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 2) b = 8'hE0;
      else if (r == 2) b = 8'hF0;
      else if (r == 3) begin
        case ($urandom_range(0, 5))
          0: b = 8'hFA; 1: b = 8'hFE; 2: b = 8'hAA;
          3: b = 8'hEE; 4: b = 8'h00; default: b = 8'hFF;
        endcase
      end else b = 8'($urandom_range(1, 255));
      kbd_rx(b, 1'b1);
      repeat ($urandom_range(0, 3)) @(posedge CLOCK_50);
    end
    kbd_rx(8'h1C, 1'b1);
    repeat (3) @(posedge CLOCK_50);

    // Pending merge: two requests during a sequence yield one more sequence.
    v  = 3'b010;
    v2 = 3'b100;
    busy_drop = 1'b0;
    exp_cmd.push_back(8'hED);
    pulse_led(v);
    wait_sent("merge_ed1");
    pulse_led(3'b001);
    pulse_led(v2);
    exp_cmd.push_back({5'b0, v});
    kbd_rx(8'hFA, 1'b0);
    wait_sent("merge_d1");
    if (!led_busy) busy_drop = 1'b1;
    exp_cmd.push_back(8'hED);
    kbd_rx(8'hFA, 1'b0);
    @(negedge CLOCK_50);
    if (!led_busy) busy_drop = 1'b1;
    wait_sent("merge_ed2");
    if (!led_busy) busy_drop = 1'b1;
    exp_cmd.push_back({5'b0, v2});
    kbd_rx(8'hFA, 1'b0);
    wait_sent("merge_d2");
    if (!led_busy) busy_drop = 1'b1;
    chk("merge_busy_held", 32'(busy_drop), 32'd0);
    kbd_rx(8'hFA, 1'b0);
    repeat (10) @(negedge CLOCK_50);
    chk("merge_busy_done", 32'(led_busy), 32'd0);
    chk("merge_no_extra", 32'(exp_cmd.size()), 32'd0);

    // Retry exhaustion: no ACK at all.
    for (int i = 0; i <= MAXR; i++) exp_cmd.push_back(8'hED);
    pulse_led(3'($urandom_range(0, 7)));
    n = 0;
    while (!kbd_error && n < 700) begin @(negedge CLOCK_50); n++; end
    chk_range("retry_window", n, 4 * ACK_T, 4 * ACK_T + 40);
    chk("retry_error", 32'(kbd_error), 32'd1);
    chk("retry_ready", 32'(kbd_ready), 32'd0);
    chk("retry_cmd_send", 32'(cmd_send), 32'd0);
    chk("retry_sends", 32'(exp_cmd.size()), 32'd0);
    exp_cmd.push_back(8'hFF);
    pulse_init();
    @(negedge CLOCK_50);
    chk("reinit_error_clr", 32'(kbd_error), 32'd0);
    finish_init("reinit");

    // Self-test timeout.
    exp_cmd.push_back(8'hFF);
    pulse_init();
    wait_sent("bat_ff");
    kbd_rx(8'hFA, 1'b0);
    n = 0;
    while (!kbd_error && n < 700) begin @(negedge CLOCK_50); n++; end
    chk_range("bat_window", n, BAT_T - 5, BAT_T + 10);
    chk("bat_ready", 32'(kbd_ready), 32'd0);
    exp_cmd.push_back(8'hFF);
    pulse_init();
    finish_init("bat_reinit");

    // Reset while a byte is being sent.
    tx_hold = 1'b1;
    exp_cmd.push_back(8'hED);
    pulse_led(3'b011);
    n = 0;
    while (!cmd_send && n < 50) begin @(negedge CLOCK_50); n++; end
    chk("rstsend_started", 32'(cmd_send), 32'd1);
    @(posedge CLOCK_50); #2;
    reset = 1'b0;
    #1;
    chk("rstsend_drop", 32'(cmd_send), 32'd0);
    chk("rstsend_data", 32'(cmd_data), 32'h00);
    chk("rstsend_busy", 32'(led_busy), 32'd0);
    m_ext = 1'b0;
    m_brk = 1'b0;
    repeat (5) @(posedge CLOCK_50);
    tx_hold = 1'b0;
    exp_cmd.push_back(8'hFF);
    @(posedge CLOCK_50); #1; reset = 1'b1;
    finish_init("rstsend_init");

    repeat (20) @(negedge CLOCK_50);
    chk("end_cmd_queue", 32'(exp_cmd.size()), 32'd0);
    chk("end_key_queue", 32'(exp_key.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_ctrl.md
Name: ps2_kbd_ctrl

Overview:
- Sequences the PS/2 transceiver's command interface for a keyboard.
- After reset it runs the reset/self-test handshake (0xFF -> 0xFA -> 0xAA), then serves LED update requests (0xED + LED byte, each ACK-checked, with resend and retry).
- Decodes the received byte stream (0xE0/0xF0 prefixes) into single-cycle key events for the game logic.
- Sits between the PS/2 transceiver and the tetris input/control logic.

Parameters:
- ACK_TIMEOUT, 1000000: clock cycles to wait for 0xFA/0xFE after a byte is sent (20 ms at 50 MHz).
- BAT_TIMEOUT, 50000000: clock cycles to wait for the self-test result after the 0xFF ACK.
- MAX_RETRY, 3: resend attempts per byte before entering ERROR.
- INIT_ON_RESET, 1: 1 = start the init sequence at reset release; 0 = start in IDLE with kbd_ready=1.

Ports:
- CLOCK_50  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- init_req  in  1  one-cycle pulse; restarts the init sequence. Honoured in IDLE and ERROR only.
- led_req  in  1  one-cycle pulse; request an LED update.
- led_value  in  3  {caps, num, scroll}; sampled in the led_req cycle.
- cmd_data  out  8  byte sent to the transceiver's the_command.
- cmd_send  out  1  to the transceiver's send_command; level signal.
- cmd_was_sent  in  1  from the transceiver's command_was_sent.
- cmd_timed_out  in  1  from the transceiver's error_communication_timed_out.
- rx_data  in  8  from the transceiver's received_data.
- rx_data_en  in  1  from the transceiver's received_data_en; one-cycle strobe.
- led_busy  out  1  LED sequence in progress or pending.
- kbd_ready  out  1  init done; keyboard present.
- kbd_error  out  1  retry limit exceeded, bad self-test, or self-test timeout.
- key_valid  out  1  one-cycle key event strobe.
- key_code  out  8  scan code, valid while key_valid=1.
- key_extended  out  1  code was preceded by 0xE0.
- key_release  out  1  code was preceded by 0xF0.

Behaviour:
- Reset (asynchronous, active-low):
  - All outputs 0; cmd_data=0x00; decoder flags, retry count, timers and pending flag cleared.
  - State = INIT_SEND if INIT_ON_RESET, else IDLE with kbd_ready=1.
  - Reset during a transfer drops cmd_send immediately; no completion is awaited.
- Byte-send sub-sequence (shared by every byte):
  - SEND: cmd_send=1, cmd_data stable, until cmd_was_sent or cmd_timed_out.
  - DROP: cmd_send=0 for exactly one cycle, so the transceiver returns to idle.
  - WAIT_ACK: timer starts at 0 on entry.
  - A cmd_timed_out in SEND counts as one retry; the same byte is resent.
- Responses while in WAIT_ACK:
  - 0xFA: advance the sequence.
  - 0xFE or timer==ACK_TIMEOUT-1: retry++ and resend the same byte.
  - retry==MAX_RETRY on a further failure: go to ERROR.
  - Any other byte is forwarded to the decoder.
  - Retry count clears when each new byte starts.
- Main states:
  - INIT_SEND(0xFF) -> WAIT_ACK -> WAIT_BAT. Timer starts on WAIT_BAT entry.
  - WAIT_BAT, 0xAA: go to IDLE and set kbd_ready=1.
  - WAIT_BAT, 0xFC, 0xFD or timer==BAT_TIMEOUT-1: go to ERROR.
  - IDLE, LED work pending: LED_CMD(0xED) -> WAIT_ACK -> LED_DATA({5'b0,led_value}) -> WAIT_ACK -> IDLE.
  - ERROR: kbd_error=1, kbd_ready=0, cmd_send=0. Left only by init_req or reset.
- kbd_error, kbd_ready and init_req:
  - kbd_error clears on entry to INIT_SEND.
  - kbd_ready clears on init_req.
  - init_req in IDLE while an LED request is pending: init wins; the pending flag is kept.
- LED requests:
  - led_req in any state sets pending=1 and latches led_value; a later request overwrites it, last value wins.
  - pending clears when LED_CMD is entered.
  - led_req in the same cycle as LED_CMD entry: the new value is latched and pending stays 1, so a second sequence follows.
  - led_busy = pending OR state in the LED sequence.
  - LED requests are served only when kbd_ready=1.
- Decoder (acts on every rx_data_en byte not consumed by WAIT_ACK or WAIT_BAT):
  - 0xE0 sets ext; 0xF0 sets brk.
  - 0xFA, 0xFE, 0xAA, 0xEE, 0x00, 0xFF arriving in IDLE or the LED states are dropped; flags unchanged.
  - Any other byte: key_valid=1 on the next cycle with key_code=byte, key_extended=ext, key_release=brk; both flags then clear.
  - Latency is exactly 1 cycle from rx_data_en.
  - key_code and flags hold their values until the next event.
- Only one byte is in flight at a time; cmd_send never rises in the cycle after DROP.

Test Plan:
- Init: release reset (ACK_TIMEOUT=100, BAT_TIMEOUT=500).
  -> cmd_data=0xFF with cmd_send=1; ack cmd_was_sent; drive rx 0xFA then 0xAA -> kbd_ready=1, kbd_error=0, no key_valid.
- LED with resend: led_req, led_value=3'b101.
  -> 0xED sent; reply 0xFE -> 0xED resent; reply 0xFA -> 0x05 sent; reply 0xFA -> led_busy falls, IDLE.
- Retry exhaustion: LED sequence with no ACK, MAX_RETRY=3.
  -> 0xED sent 4 times, each 100 cycles apart -> kbd_error=1, cmd_send=0; init_req -> 0xFF sent, kbd_error=0.
- Decode: rx E0, F0, 75.
  -> one key_valid, 1 cycle after the 0x75 strobe: code=0x75, extended=1, release=1; then rx 1C -> code=0x1C, extended=0, release=0.
- Pending merge: led_req 3'b001 then 3'b100 during an active LED sequence.
  -> exactly one extra sequence follows, data byte 0x04; led_busy stays high throughout.
- Reset mid-send: assert reset while cmd_send=1.
  -> cmd_send=0 asynchronously; after release, 0xFF is sent again.
